threshold_persist_detector: RTL and testbench
=============================================

Name: threshold_persist_detector

Overview:
- Parametrised successor to the combinational 2-of-3 pair/triple detector.
- Counts asserted bits across N_IN input lines and compares the count against THRESH.
- The result is debounced: the output only changes after HOLD consecutive valid samples agree.
- Counts rising detections. Sits between sampled sensor/vote inputs and downstream control logic.

Parameters:
N_IN, 3, number of input lines; legal range 2..32.
THRESH, 2, minimum number of asserted bits that counts as a hit; legal range 1..N_IN.
HOLD, 2, consecutive agreeing valid samples needed to change the output; legal range 1..255.
CNT_W, 8, width of the saturating detection-event counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
clr  input  1  synchronous clear of FSM, run counter and event counter.
in_val  input  1  in_bits holds a sample this cycle.
in_bits  input  N_IN  sampled input lines.
out  output  1  debounced detection, registered.
rise  output  1  one-cycle pulse on each entry to ACTIVE.
pop  output  POP_W  registered popcount of the last valid sample; POP_W = $clog2(N_IN+1).
event_count  output  CNT_W  number of rise pulses; saturates at all-ones.

Behaviour:
- Reset and clock: one clock. Reset is asynchronous and active-low (rst_n); clock is clk.
- Reset values: state=IDLE, run=0, out=0, rise=0, pop=0, event_count=0.
- Hit: hit = (popcount(in_bits) >= THRESH), combinational.
  - pop and state update on the edge where in_val=1.
  - When in_val=0, all state holds and rise=0.
- Latency: out and rise reflect a sample one edge after that sample is accepted.
- States: out=1 in ACTIVE and REL, out=0 in IDLE and ARM.
  - IDLE:
    - val&hit, HOLD=1 → ACTIVE.
    - val&hit, HOLD>1 → ARM with run=1.
    - Otherwise stay.
  - ARM:
    - val&hit → run+1; when run+1==HOLD → ACTIVE, run=0.
    - val&!hit → IDLE, run=0.
  - ACTIVE:
    - val&!hit, HOLD=1 → IDLE.
    - val&!hit, HOLD>1 → REL with run=1.
    - val&hit → stay.
  - REL:
    - val&!hit → run+1; when run+1==HOLD → IDLE, run=0.
    - val&hit → ACTIVE, run=0.
- rise: asserted for exactly one cycle on the edge that enters ACTIVE from IDLE or ARM. A REL→ACTIVE transition does not pulse rise.
- event_count: +1 on every rise. At 2^CNT_W-1 it holds and never wraps.
- clr:
  - Forces IDLE, run=0, event_count=0, rise=0.
  - pop is left unchanged.
  - clr beats a simultaneous in_val; that sample is discarded.
- Reset mid-run (rst_n low at any time) returns all registers to reset values immediately.
- Run counter width is $clog2(HOLD+1); run never exceeds HOLD-1 in a stored state.
- Popcount is unsigned; no overflow is possible at POP_W.

Optional Feature:
- Macro: THRESHOLD_PERSIST_STICKY_EN.
- Defined: ACTIVE is latched.
  - val&!hit keeps ACTIVE; REL is unreachable.
  - out returns to 0 only via clr or rst_n.
- Undefined: release hysteresis applies exactly as in Behaviour.

Decomposition:
- Package threshold_persist_pkg:
  - State enum: IDLE=2'b00, ARM=2'b01, ACTIVE=2'b10, REL=2'b11.
  - Localparam helper for POP_W.
- Sub-module popcount_n: parameter N; input N bits; output $clog2(N+1)-bit count; purely combinational adder tree.
- Top module holds the FSM, run counter, registered outputs and event counter.

Test Plan:
1. Defaults (N_IN=3, THRESH=2, HOLD=2), apply rst_n=0 then release → out=0, rise=0, pop=0, event_count=0.
2. Defaults, valid samples 3'b011, 3'b011 → after 2nd edge out=1, rise=1 for one cycle, event_count=1, pop=2; after 1st edge out=0.
3. From ACTIVE, samples 3'b001, 3'b110, 3'b001, 3'b001 → out stays 1 through the 3'b110 re-hit and falls after the last edge; event_count unchanged; no rise pulse.
4. Defaults, sample 3'b111, then in_val=0 for 5 cycles, then 3'b101 → stays in ARM while idle; out=1 after the 3'b101 edge.
5. CNT_W=2, repeat the detect/release cycle 5 times → event_count reads 1, 2, 3, 3, 3.
6. Assert clr together with a hitting sample while in ARM → IDLE, event_count=0. Then rst_n low mid-REL → out=0 asynchronously. With THRESHOLD_PERSIST_STICKY_EN defined, a !hit sequence leaves out=1 until clr.

Source files
------------

// File: rtl/threshold_persist_pkg.sv
// Shared types and width helpers for the threshold persistence detector.
package threshold_persist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARM    = 2'b01,
    ACTIVE = 2'b10,
    REL    = 2'b11
  } state_e;

  // Bits needed to hold a count of 0..n.
  function automatic int pop_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/threshold_persist_detector_popcount.sv
// Combinational popcount of N bits built as a balanced binary adder tree.
module popcount_n
  import threshold_persist_pkg::*;
#(
  parameter int N = 3,
  localparam int CW = pop_width(N)
) (
  input  logic [N-1:0]  in_bits,
  output logic [CW-1:0] count
);

  localparam int LEVELS = (N > 1) ? $clog2(N) : 1;
  localparam int NP     = 1 << LEVELS;

  // Level 0 holds the zero-padded leaves; each later level halves the width.
  for (genvar gl = 0; gl <= LEVELS; gl++) begin : g_lvl
    localparam int W = NP >> gl;
    logic [CW-1:0] sum [W];
    if (gl == 0) begin : g_leaf
      for (genvar gi = 0; gi < W; gi++) begin : g_bit
        if (gi < N) begin : g_used
          assign sum[gi] = CW'(in_bits[gi]);
        end else begin : g_pad
          assign sum[gi] = '0;
        end
      end
    end else begin : g_add
      for (genvar gi = 0; gi < W; gi++) begin : g_node
        assign sum[gi] = g_lvl[gl-1].sum[2*gi] + g_lvl[gl-1].sum[2*gi+1];
      end
    end
  end

  assign count = g_lvl[LEVELS].sum[0];

endmodule

// File: rtl/threshold_persist_detector.sv
// Debounced N-input threshold detector with rise pulse and saturating event counter.
// Build option: define THRESHOLD_PERSIST_STICKY_EN to latch ACTIVE until clr/reset.
module threshold_persist_detector
  import threshold_persist_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int THRESH = 2,
  parameter int HOLD   = 2,
  parameter int CNT_W  = 8,
  localparam int POP_W = pop_width(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_val,
  input  logic [N_IN-1:0]  in_bits,
  output logic             out,
  output logic             rise,
  output logic [POP_W-1:0] pop,
  output logic [CNT_W-1:0] event_count
);

  localparam int RUN_W = $clog2(HOLD + 1);
  localparam logic [RUN_W-1:0] HOLD_R   = RUN_W'(HOLD);
  localparam logic [POP_W-1:0] THRESH_R = POP_W'(THRESH);

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic [POP_W-1:0] pop_q, pop_d;
  logic [CNT_W-1:0] event_count_q, event_count_d;

  logic [POP_W-1:0] pop_now;
  logic             hit;
  logic [RUN_W-1:0] run_inc;

  popcount_n #(.N(N_IN)) u_popcount (
    .in_bits (in_bits),
    .count   (pop_now)
  );

  assign hit     = (pop_now >= THRESH_R);
  assign run_inc = run_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    run_d         = run_q;
    rise_d        = 1'b0;
    pop_d         = pop_q;
    event_count_d = event_count_q;

    if (clr) begin
      state_d       = IDLE;
      run_d         = '0;
      event_count_d = '0;
    end else if (in_val) begin
      pop_d = pop_now;
      case (state_q)
        IDLE: begin
          if (hit) begin
            if (HOLD == 1) begin
              state_d = ACTIVE;
              rise_d  = 1'b1;
            end else begin
              state_d = ARM;
              run_d   = RUN_W'(1);
            end
          end
        end
        ARM: begin
          if (hit) begin
            if (run_inc == HOLD_R) begin
              state_d = ACTIVE;
              run_d   = '0;
              rise_d  = 1'b1;
            end else begin
              run_d = run_inc;
            end
          end else begin
            state_d = IDLE;
            run_d   = '0;
          end
        end
        ACTIVE: begin
`ifdef THRESHOLD_PERSIST_STICKY_EN
          state_d = ACTIVE;
`else
          if (!hit) begin
            if (HOLD == 1) begin
              state_d = IDLE;
            end else begin
              state_d = REL;
              run_d   = RUN_W'(1);
            end
          end
`endif
        end
        REL: begin
          if (hit) begin
            state_d = ACTIVE;
            run_d   = '0;
          end else if (run_inc == HOLD_R) begin
            state_d = IDLE;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase

      // Saturate rather than wrap so a stuck-busy input never looks quiet.
      if (rise_d && (event_count_q != {CNT_W{1'b1}})) begin
        event_count_d = event_count_q + 1'b1;
      end
    end

    out_d = (state_d == ACTIVE) || (state_d == REL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      run_q         <= '0;
      out_q         <= 1'b0;
      rise_q        <= 1'b0;
      pop_q         <= '0;
      event_count_q <= '0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      out_q         <= out_d;
      rise_q        <= rise_d;
      pop_q         <= pop_d;
      event_count_q <= event_count_d;
    end
  end

  assign out         = out_q;
  assign rise        = rise_q;
  assign pop         = pop_q;
  assign event_count = event_count_q;

endmodule

// File: tb/tb_threshold_persist_detector.sv
// Directed-vector bench for threshold_persist_detector (default and CNT_W=2 instances).
module tb_threshold_persist_detector;

`ifdef THRESHOLD_PERSIST_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_val = 1'b0;
  logic [2:0] in_bits = 3'b000;

  logic       out, rise;
  logic [1:0] pop;
  logic [7:0] event_count;
  logic       out_c2, rise_c2;
  logic [1:0] pop_c2;
  logic [1:0] event_count_c2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  threshold_persist_detector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .in_val      (in_val),
    .in_bits     (in_bits),
    .out         (out),
    .rise        (rise),
    .pop         (pop),
    .event_count (event_count)
  );

  threshold_persist_detector #(.CNT_W(2)) dut_c2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .in_val      (in_val),
    .in_bits     (in_bits),
    .out         (out_c2),
    .rise        (rise_c2),
    .pop         (pop_c2),
    .event_count (event_count_c2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [2:0] b, input logic c);
    in_val  = v;
    in_bits = b;
    clr     = c;
    @(posedge clk);
    #1;
    in_val = 1'b0;
    clr    = 1'b0;
  endtask

  initial begin
    // 1: reset state
    #12;
    chk("rst_out", out, 0);
    chk("rst_rise", rise, 0);
    chk("rst_pop", pop, 0);
    chk("rst_evt", event_count, 0);
    rst_n = 1'b1;

    // 2: two hitting samples -> ACTIVE
    cyc(1, 3'b011, 0);
    chk("t2_e1_out", out, 0);
    chk("t2_e1_rise", rise, 0);
    chk("t2_e1_pop", pop, 2);
    cyc(1, 3'b011, 0);
    chk("t2_e2_out", out, 1);
    chk("t2_e2_rise", rise, 1);
    chk("t2_e2_evt", event_count, 1);
    chk("t2_e2_pop", pop, 2);
    cyc(0, 3'b000, 0);
    chk("t2_idle_rise", rise, 0);
    chk("t2_idle_out", out, 1);

    // 3: release hysteresis with a re-hit in REL
    cyc(1, 3'b001, 0);
    chk("t3_a_out", out, 1);
    chk("t3_a_pop", pop, 1);
    cyc(1, 3'b110, 0);
    chk("t3_b_out", out, 1);
    chk("t3_b_rise", rise, 0);
    cyc(1, 3'b001, 0);
    chk("t3_c_out", out, 1);
    cyc(1, 3'b001, 0);
    chk("t3_d_out", out, STICKY ? 1 : 0);
    chk("t3_d_rise", rise, 0);
    chk("t3_d_evt", event_count, 1);

    // 4: ARM holds across invalid cycles (sticky build re-arms via clr first)
    if (STICKY) cyc(0, 3'b000, 1);
    cyc(1, 3'b111, 0);
    chk("t4_arm_out", out, 0);
    chk("t4_arm_pop", pop, 3);
    for (int i = 0; i < 5; i++) cyc(0, 3'b000, 0);
    chk("t4_hold_out", out, 0);
    chk("t4_hold_pop", pop, 3);
    cyc(1, 3'b101, 0);
    chk("t4_act_out", out, 1);
    chk("t4_act_rise", rise, 1);
    chk("t4_act_pop", pop, 2);

    // 5: saturation of the 2-bit counter
    cyc(0, 3'b000, 1);
    chk("t5_clr_evt", event_count, 0);
    chk("t5_clr_evt_c2", event_count_c2, 0);
    chk("t5_clr_out", out, 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 3'b011, 0);
      cyc(1, 3'b011, 0);
      chk($sformatf("t5_evt_%0d", k), event_count, STICKY ? 1 : k);
      chk($sformatf("t5_evt_c2_%0d", k), event_count_c2,
          STICKY ? 1 : ((k > 3) ? 3 : k));
      cyc(1, 3'b000, 0);
      cyc(1, 3'b000, 0);
    end

    // 6: clr beats a hitting sample in ARM; pop untouched
    cyc(0, 3'b000, 1);
    cyc(1, 3'b011, 0);
    chk("t6_arm_out", out, 0);
    cyc(1, 3'b111, 1);
    chk("t6_clr_out", out, 0);
    chk("t6_clr_rise", rise, 0);
    chk("t6_clr_evt", event_count, 0);
    chk("t6_clr_pop", pop, 2);
    cyc(1, 3'b011, 0);
    chk("t6_rearm_out", out, 0);
    cyc(1, 3'b011, 0);
    chk("t6_act_out", out, 1);
    chk("t6_act_evt", event_count, 1);
    cyc(1, 3'b000, 0);
    chk("t6_rel_out", out, 1);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_out", out, 0);
    chk("t6_arst_evt", event_count, 0);
    chk("t6_arst_pop", pop, 0);
    #1;
    rst_n = 1'b1;

    // Persistence after a no-hit sequence, then clr
    cyc(1, 3'b011, 0);
    cyc(1, 3'b011, 0);
    chk("t6_s_on", out, 1);
    for (int i = 0; i < 3; i++) cyc(1, 3'b000, 0);
    chk("t6_s_after_nohit", out, STICKY ? 1 : 0);
    cyc(0, 3'b000, 1);
    chk("t6_s_clr", out, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
